// File: rtl/verin_pio_pkg.sv
// Shared constants for the verin panel PIO input port: register addresses, edge selectors, bus width.
package verin_pio_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/verin_pio_debounce.sv
// One-channel debouncer: a level change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
// Latency DEBOUNCE_CYCLES cycles from s2 to level; no backpressure.
module verin_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic s2,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      level <= s2;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/verin_avalon_pio_in.sv
// Avalon-MM input port for the verin panel: sync, optional debounce (VERIN_PIO_DEBOUNCE_EN), edge capture, maskable IRQ.
// Read latency 1 cycle, no wait states; pin-to-level 3 cycles, or 2+DEBOUNCE_CYCLES with the debouncer.
module verin_avalon_pio_in
  import verin_pio_pkg::*;
#(
  parameter int WIDTH           = 8,
  parameter int EDGE_TYPE       = 0,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  input  logic [WIDTH-1:0]  in_port,
  output logic              irq
);

  if (WIDTH < 1 || WIDTH > DATA_W || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("verin_avalon_pio_in: illegal WIDTH or DEBOUNCE_CYCLES");
  end

  logic [WIDTH-1:0]  s1, s2, level, lvl_q;
  logic [WIDTH-1:0]  rise, fall, edge_sel, w1c;
  logic [WIDTH-1:0]  irq_mask, edge_capture;
  logic [DATA_W-1:0] rd_mux;
  logic              wr;
  logic              unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
    end
  end

`ifdef VERIN_PIO_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    verin_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .s2    (s2[i]),
      .level (level[i])
    );
  end
`else
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level <= '0;
    else       level <= s2;
  end
`endif

  always_comb begin
    rise = level & ~lvl_q;
    fall = ~level & lvl_q;
    case (EDGE_TYPE)
      EDGE_FALL: edge_sel = fall;
      EDGE_ANY:  edge_sel = rise | fall;
      default:   edge_sel = rise;
    endcase
  end

  always_comb begin
    w1c = '0;
    if (wr && address == ADDR_EDGE_CAP) w1c = writedata[WIDTH-1:0];
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:     rd_mux = DATA_W'(level);
      ADDR_IRQ_MASK: rd_mux = DATA_W'(irq_mask);
      ADDR_EDGE_CAP: rd_mux = DATA_W'(edge_capture);
      default:       rd_mux = '0;
    endcase
  end

  // A new edge outranks a same-cycle clear so no event is lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lvl_q        <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      readdata     <= '0;
    end else begin
      lvl_q        <= level;
      edge_capture <= (edge_capture & ~w1c) | edge_sel;
      readdata     <= rd_mux;
      if (wr && address == ADDR_IRQ_MASK) irq_mask <= writedata[WIDTH-1:0];
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_verin_avalon_pio_in.sv
// Directed bench for verin_avalon_pio_in at WIDTH=8, DEBOUNCE_CYCLES=4, EDGE_TYPE=0, with or without the debouncer.
module tb_verin_avalon_pio_in;

`ifdef VERIN_PIO_DEBOUNCE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [7:0]  in_port = '0;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  verin_avalon_pio_in #(
    .WIDTH(8), .EDGE_TYPE(0), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick();
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    tick(2);
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL reset_readdata: got %h want %h", readdata, 32'h0); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_reg(2'(a), d);
      n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_reg%0d: got %h want %h", a, d, 32'h0); end
    end
  endtask

  task automatic test_data_latency;
    logic [31:0] d;
    address = 2'd0;
    in_port = 8'h05;
    tick(LAT);
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL data_early: got %h want %h", readdata, 32'h0); end
    tick();
    n_cmp++; if (readdata !== 32'h05) begin n_bad++; $display("FAIL data_latency: got %h want %h", readdata, 32'h05); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'h05) begin n_bad++; $display("FAIL data_edge_cap: got %h want %h", d, 32'h05); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL data_irq_unmasked: got %b want 0", irq); end
  endtask

  task automatic test_glitch;
    logic [31:0] d;
    logic [31:0] exp_cap;
`ifdef VERIN_PIO_DEBOUNCE_EN
    exp_cap = 32'h15;
`else
    exp_cap = 32'h1D;
`endif
    in_port = 8'h0D; tick(3);
    in_port = 8'h05; tick(10);
    in_port = 8'h15; tick(4);
    in_port = 8'h05; tick(12);
    rd_reg(2'd0, d);
    n_cmp++; if (d !== 32'h05) begin n_bad++; $display("FAIL glitch_data: got %h want %h", d, 32'h05); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== exp_cap) begin n_bad++; $display("FAIL glitch_edge_cap: got %h want %h", d, exp_cap); end
  endtask

  task automatic test_regs;
    logic [31:0] d;
    wr_reg(2'd1, 32'hFFFF_FFFF);
    rd_reg(2'd1, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reserved_read: got %h want %h", d, 32'h0); end
    wr_reg(2'd2, 32'hFFFF_FFFF);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_mask_all: got %b want 1", irq); end
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'hFF) begin n_bad++; $display("FAIL mask_upper_bits: got %h want %h", d, 32'hFF); end
    wr_reg(2'd2, 32'h0);
    n_cmp++; if (readdata !== 32'hFF) begin n_bad++; $display("FAIL read_before_write: got %h want %h", readdata, 32'hFF); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_mask_none: got %b want 0", irq); end
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mask_cleared: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_irq;
    logic [31:0] d;
    wr_reg(2'd3, 32'hFF);
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL w1c_all: got %h want %h", d, 32'h0); end
    wr_reg(2'd2, 32'h01);
    in_port = 8'h04; tick(LAT + 3);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_fall_ignored: got %b want 0", irq); end
    in_port = 8'h05; tick(LAT);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_rise: got %b want 1", irq); end
    wr_reg(2'd3, 32'h01);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear: got %b want 0", irq); end
    in_port = 8'h07; tick(LAT + 2);
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked_bit1: got %b want 0", irq); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'h02) begin n_bad++; $display("FAIL cap_bit1: got %h want %h", d, 32'h02); end
  endtask

  task automatic test_w1c_collision;
    logic [31:0] d;
    wr_reg(2'd3, 32'hFF);
    in_port = 8'h03; tick(LAT + 2);
    in_port = 8'h07; tick(LAT);
    wr_reg(2'd3, 32'h04);
    rd_reg(2'd3, d);
    n_cmp++; if (d !== 32'h04) begin n_bad++; $display("FAIL set_beats_w1c: got %h want %h", d, 32'h04); end
  endtask

  task automatic test_short_pulse;
    logic [31:0] d;
    logic [31:0] exp_hi, exp_cap;
`ifdef VERIN_PIO_DEBOUNCE_EN
    exp_hi = 32'h07; exp_cap = 32'h00;
`else
    exp_hi = 32'h87; exp_cap = 32'h80;
`endif
    wr_reg(2'd3, 32'hFF);
    address = 2'd0;
    in_port = 8'h87; tick();
    in_port = 8'h07; tick(3);
    n_cmp++; if (readdata !== exp_hi) begin n_bad++; $display("FAIL pulse_data_hi: got %h want %h", readdata, exp_hi); end
    tick();
    n_cmp++; if (readdata !== 32'h07) begin n_bad++; $display("FAIL pulse_data_lo: got %h want %h", readdata, 32'h07); end
    rd_reg(2'd3, d);
    n_cmp++; if (d !== exp_cap) begin n_bad++; $display("FAIL pulse_edge_cap: got %h want %h", d, exp_cap); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    wr_reg(2'd2, 32'hFF);
    in_port = 8'h0F; tick(LAT + 2);
    n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    address = 2'd3;
    in_port = 8'h07; tick(3);
    reset = 1'b1;
    #1;
    n_cmp++; if (readdata !== 32'h0) begin n_bad++; $display("FAIL midreset_readdata: got %h want %h", readdata, 32'h0); end
    n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq: got %b want 0", irq); end
    tick(2);
    reset = 1'b0;
    rd_reg(2'd0, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL postreset_data: got %h want %h", d, 32'h0); end
    rd_reg(2'd2, d);
    n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL postreset_mask: got %h want %h", d, 32'h0); end
  endtask

  initial begin
    test_reset();
    test_data_latency();
    test_glitch();
    test_regs();
    test_irq();
    test_w1c_collision();
    test_short_pulse();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
